// File: rtl/set_cmd_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : set_cmd_feeder_if
// Brief    : Bundles the host command channel, the SET engine load/result
//            channel and the tagged result channel of set_cmd_feeder.
//            'slave' is the feeder's view, 'master' is the environment's view.
// Revision : 1.0 - initial release
// ============================================================================
interface set_cmd_feeder_if #(
  parameter int TAG_W = 4
);

  // Host command channel
  logic             cmd_valid;
  logic             cmd_ready;
  logic [23:0]      cmd_central;
  logic [11:0]      cmd_radius;
  logic [1:0]       cmd_mode;

  // Engine load / result channel
  logic             set_en;
  logic [23:0]      set_central;
  logic [11:0]      set_radius;
  logic [1:0]       set_mode;
  logic             set_busy;
  logic             set_valid;
  logic [7:0]       set_candidate;

  // Tagged result channel
  logic             res_valid;
  logic [7:0]       res_candidate;
  logic [TAG_W-1:0] res_tag;

  modport slave (
    input  cmd_valid, cmd_central, cmd_radius, cmd_mode,
    output cmd_ready,
    output set_en, set_central, set_radius, set_mode,
    input  set_busy, set_valid, set_candidate,
    output res_valid, res_candidate, res_tag
  );

  modport master (
    output cmd_valid, cmd_central, cmd_radius, cmd_mode,
    input  cmd_ready,
    input  set_en, set_central, set_radius, set_mode,
    output set_busy, set_valid, set_candidate,
    input  res_valid, res_candidate, res_tag
  );

endinterface
`default_nettype wire

// File: rtl/set_cmd_feeder.sv
`default_nettype none
// ============================================================================
// Module   : set_cmd_feeder
// Brief    : Command scheduler in front of the SET circle-coverage engine.
//            Host commands are buffered in a DEPTH-entry FIFO, each one is
//            handed to the engine during its single busy-low read cycle, and
//            the engine's count is returned tagged with the command's
//            sequence number. Engine results that do not belong to an issued
//            command (dummy runs) are dropped.
// Options  : SET_FEED_STAT_EN - adds 8-bit saturating counters stat_issued,
//            stat_done and stat_dummy.
// Revision : 1.0 - initial release
// ============================================================================
module set_cmd_feeder #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  set_cmd_feeder_if.slave   bus,
  output logic              idle
`ifdef SET_FEED_STAT_EN
  ,
  output logic [7:0]        stat_issued,
  output logic [7:0]        stat_done,
  output logic [7:0]        stat_dummy
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [23:0]      central;
    logic [11:0]      radius;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
  logic [7:0]       res_cand_q, res_cand_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  entry_t           mem_q [DEPTH];

  logic             cmd_ready;
  logic             push;
  logic             pop;
  logic             set_en;
  entry_t           head;
  entry_t           new_entry;

  // Ready looks only at the registered count, so a full FIFO never accepts
  // even when the head is being popped in the same cycle.
  assign cmd_ready = (count_q != CNT_W'(DEPTH));
  assign push      = bus.cmd_valid && cmd_ready;
  assign pop       = set_en;
  assign head      = mem_q[rd_ptr_q];

  assign new_entry = '{central: bus.cmd_central,
                       radius:  bus.cmd_radius,
                       mode:    bus.cmd_mode,
                       tag:     tag_q};

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.cmd_ready     = cmd_ready;
  assign bus.set_en        = set_en;
  assign bus.set_central   = head.central;
  assign bus.set_radius    = head.radius;
  assign bus.set_mode      = head.mode;
  assign bus.res_valid     = (state_q == ST_RESP);
  assign bus.res_candidate = res_cand_q;
  assign bus.res_tag       = res_tag_q;
  assign idle              = (count_q == '0) && (state_q == ST_IDLE);

  // FIFO pointer, occupancy and sequence-tag bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    tag_d    = tag_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      tag_d    = tag_q + TAG_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scheduler: issue in the engine read cycle, wait for its result, report it
  always_comb begin
    state_d    = state_q;
    set_en     = 1'b0;
    cur_tag_d  = cur_tag_q;
    res_cand_d = res_cand_q;
    res_tag_d  = res_tag_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A set_valid here comes from a run we did not load; it is ignored.
        if (!bus.set_busy) begin
          set_en    = 1'b1;
          cur_tag_d = head.tag;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.set_valid) begin
          res_cand_d = bus.set_candidate;
          res_tag_d  = cur_tag_q;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        // Going straight to ISSUE lets the next command catch the engine's
        // read cycle, which falls on the cycle after this one.
        state_d = (count_q != '0) ? ST_ISSUE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and result registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tag_q      <= '0;
      cur_tag_q  <= '0;
      res_cand_q <= '0;
      res_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tag_q      <= tag_d;
      cur_tag_q  <= cur_tag_d;
      res_cand_q <= res_cand_d;
      res_tag_q  <= res_tag_d;
    end
  end

  // Command storage; contents are only read when the count says they are
  // valid, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

`ifdef SET_FEED_STAT_EN
  // --------------------------------------------------------------------------
  // Activity counters
  // --------------------------------------------------------------------------
  logic [7:0] stat_issued_q, stat_issued_d;
  logic [7:0] stat_done_q,   stat_done_d;
  logic [7:0] stat_dummy_q,  stat_dummy_d;
  logic       dummy_valid;

  // Any engine result outside RUN is one that gets discarded
  assign dummy_valid = bus.set_valid && (state_q != ST_RUN);

  // Saturating increments of the three activity counters
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_done_d   = stat_done_q;
    stat_dummy_d  = stat_dummy_q;
    if (set_en && (stat_issued_q != 8'hFF)) begin
      stat_issued_d = stat_issued_q + 8'd1;
    end
    if ((state_q == ST_RESP) && (stat_done_q != 8'hFF)) begin
      stat_done_d = stat_done_q + 8'd1;
    end
    if (dummy_valid && (stat_dummy_q != 8'hFF)) begin
      stat_dummy_d = stat_dummy_q + 8'd1;
    end
  end

  // Counter registers, cleared with the rest of the block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_done_q   <= '0;
      stat_dummy_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_done_q   <= stat_done_d;
      stat_dummy_q  <= stat_dummy_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_done   = stat_done_q;
  assign stat_dummy  = stat_dummy_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_set_cmd_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_set_cmd_feeder
// Brief    : Self-checking bench for set_cmd_feeder with a free-running SET
//            engine model and a transaction-level reference of the feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_cmd_feeder;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic idle;

  always #5 clk = ~clk;

  set_cmd_feeder_if #(.TAG_W(TAG_W)) bus ();

`ifdef SET_FEED_STAT_EN
  logic [7:0] stat_issued, stat_done, stat_dummy;
`endif

  set_cmd_feeder #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .idle  (idle)
`ifdef SET_FEED_STAT_EN
    ,
    .stat_issued (stat_issued),
    .stat_done   (stat_done),
    .stat_dummy  (stat_dummy)
`endif
  );

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Coverage count of the 16x16 grid: the engine's job, used both by the
  // engine model and by the reference.
  function automatic bit in_circ(int x, int y, logic [3:0] cx, logic [3:0] cy, logic [3:0] r);
    int dx, dy;
    dx = x - int'(cx);
    dy = y - int'(cy);
    return (dx * dx + dy * dy) <= (int'(r) * int'(r));
  endfunction

  function automatic logic [7:0] cover_count(logic [23:0] c, logic [11:0] r, logic [1:0] m);
    int n = 0;
    bit a, b, cc, hit;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a  = in_circ(x, y, c[23:20], c[19:16], r[11:8]);
        b  = in_circ(x, y, c[15:12], c[11:8],  r[7:4]);
        cc = in_circ(x, y, c[7:4],   c[3:0],   r[3:0]);
        case (m)
          2'd0:    hit = a;
          2'd1:    hit = a && b;
          2'd2:    hit = a && !b;
          default: hit = a && b && cc;
        endcase
        if (hit) n++;
      end
    end
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  // --------------------------------------------------------------------------
  // Engine model: read cycle (busy low), run, valid pulse, one gap, read again
  // --------------------------------------------------------------------------
  int          eng_run_len = 0;   // 0 selects a random run length
  logic        eng_ld;
  logic [23:0] eng_c;
  logic [11:0] eng_r;
  logic [1:0]  eng_m;

  initial begin
    int n;
    bus.set_busy      = 1'b1;
    bus.set_valid     = 1'b0;
    bus.set_candidate = 8'd0;
    @(posedge clk); #1;
    forever begin
      bus.set_busy  = 1'b0;
      bus.set_valid = 1'b0;
      @(negedge clk);
      eng_ld = bus.set_en;
      eng_c  = bus.set_central;
      eng_r  = bus.set_radius;
      eng_m  = bus.set_mode;
      @(posedge clk); #1;
      bus.set_busy = 1'b1;
      n = (eng_run_len == 0) ? int'($urandom_range(1, 5)) : eng_run_len;
      repeat (n - 1) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      bus.set_valid     = 1'b1;
      bus.set_candidate = eng_ld ? cover_count(eng_c, eng_r, eng_m) : 8'($urandom);
      @(posedge clk); #1;
      bus.set_valid = 1'b0;
      @(posedge clk); #1;
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: queue of accepted commands, one command in flight
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [23:0]      c;
    logic [11:0]      r;
    logic [1:0]       m;
    logic [TAG_W-1:0] t;
  } cmd_t;

  cmd_t             q[$];
  cmd_t             cur;
  cmd_t             nc;
  bit               run, resp, prev_can;
  logic [TAG_W-1:0] tag_ctr;
  logic [7:0]       hold_cand;
  logic [TAG_W-1:0] hold_tag;
  int               cyc = 0;
  int               last_valid_cyc = 0;
  int               res_seen = 0;
  bit               b2b_watch = 0;
  int               b2b_issues = 0;
  int               m_issued, m_done, m_dummy;

  initial begin
    bit exp_en, push_ok, nxt_can, real_valid;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check_eq("rst_cmd_ready", bus.cmd_ready, 1);
        check_eq("rst_set_en", bus.set_en, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_res_valid", bus.res_valid, 0);
        check_eq("rst_res_cand", bus.res_candidate, 0);
        check_eq("rst_res_tag", bus.res_tag, 0);
`ifdef SET_FEED_STAT_EN
        check_eq("rst_stats", {stat_issued, stat_done, stat_dummy}, 0);
`endif
        q.delete();
        run = 0; resp = 0; prev_can = 0;
        tag_ctr = '0; hold_cand = '0; hold_tag = '0;
        m_issued = 0; m_done = 0; m_dummy = 0;
      end else begin
        exp_en = prev_can && !bus.set_busy;
        check_eq("set_en", bus.set_en, exp_en);
        check_eq("cmd_ready", bus.cmd_ready, q.size() < DEPTH);
        check_eq("idle", idle, (q.size() == 0) && !run && !resp);
        check_eq("res_valid", bus.res_valid, resp);
        check_eq("res_candidate", bus.res_candidate, hold_cand);
        check_eq("res_tag", bus.res_tag, hold_tag);
`ifdef SET_FEED_STAT_EN
        check_eq("stat_issued", stat_issued, m_issued);
        check_eq("stat_done", stat_done, m_done);
        check_eq("stat_dummy", stat_dummy, m_dummy);
`endif
        if (exp_en && q.size() > 0) begin
          check_eq("set_central", bus.set_central, q[0].c);
          check_eq("set_radius", bus.set_radius, q[0].r);
          check_eq("set_mode", bus.set_mode, q[0].m);
        end
        if (exp_en && b2b_watch) begin
          b2b_issues++;
          if (b2b_issues > 1) check_eq("b2b_gap", cyc - last_valid_cyc, 2);
        end
        if (bus.res_valid) res_seen++;

        // advance the model by one cycle
        push_ok    = bus.cmd_valid && (q.size() < DEPTH);
        nxt_can    = (q.size() > 0) && !run && !exp_en;
        real_valid = run && bus.set_valid;
        if (bus.set_valid && !run && m_dummy < 255) m_dummy++;
        if (resp && m_done < 255) m_done++;
        if (exp_en && q.size() > 0) begin
          cur = q.pop_front();
          if (m_issued < 255) m_issued++;
        end
        if (push_ok) begin
          nc.c = bus.cmd_central; nc.r = bus.cmd_radius; nc.m = bus.cmd_mode; nc.t = tag_ctr;
          q.push_back(nc);
          tag_ctr = tag_ctr + 1'b1;
        end
        if (real_valid) begin
          hold_cand      = cover_count(cur.c, cur.r, cur.m);
          hold_tag       = cur.t;
          last_valid_cyc = cyc;
        end
        run      = (run && !bus.set_valid) || exp_en;
        resp     = real_valid;
        prev_can = nxt_can;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Host side
  // --------------------------------------------------------------------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_cmd(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int k = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_central = c;
    bus.cmd_radius  = r;
    bus.cmd_mode    = m;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.cmd_ready && k < 200);
    check_eq("push_accept", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string nm, input logic [7:0] ec, input logic [TAG_W-1:0] et);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.res_valid && k < 300);
    check_eq({nm, "_valid"}, bus.res_valid, 1);
    check_eq({nm, "_cand"}, bus.res_candidate, ec);
    check_eq({nm, "_tag"}, bus.res_tag, et);
    @(posedge clk); #1;
  endtask

  task automatic wait_issue(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.set_en && k < 200);
    check_eq(nm, bus.set_en, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, base, k;
    bus.cmd_valid   = 1'b0;
    bus.cmd_central = '0;
    bus.cmd_radius  = '0;
    bus.cmd_mode    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Empty FIFO: engine dummy runs are dropped, then a normal command
    repeat (30) @(posedge clk);
    #1;
    push_cmd(24'h440000, 12'h200, 2'd0);
    wait_res("single_m0", 8'd13, 0);

    do_reset();
    push_cmd(24'h444400, 12'h220, 2'd1);
    wait_res("ab_m1", 8'd13, 0);

    do_reset();
    push_cmd(24'h444400, 12'h220, 2'd2);
    wait_res("ab_m2", 8'd0, 0);

    // Three commands back to back
    do_reset();
    b2b_issues = 0;
    b2b_watch  = 1;
    push_cmd(24'h440000, 12'h100, 2'd0);
    push_cmd(24'h440000, 12'h200, 2'd0);
    push_cmd(24'h440000, 12'h300, 2'd0);
    wait_res("b2b_r1", 8'd5, 0);
    wait_res("b2b_r2", 8'd13, 1);
    wait_res("b2b_r3", 8'd29, 2);
    b2b_watch = 0;

    // FIFO full while the engine is in a long run
    do_reset();
    eng_run_len = 30;
    base = res_seen;
    push_cmd(24'($urandom), 12'h321, 2'($urandom));
    wait_issue("depth_first_issue");
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      bus.cmd_valid   = 1'b1;
      bus.cmd_central = 24'($urandom);
      bus.cmd_radius  = 12'($urandom);
      bus.cmd_mode    = 2'($urandom);
      @(negedge clk);
      if (bus.cmd_ready) acc++;
      @(posedge clk); #1;
    end
    check_eq("depth_accepted", acc, DEPTH);
    check_eq("depth_ready_low", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    eng_run_len = 0;
    push_cmd(24'($urandom), 12'h444, 2'd0);
    k = 0;
    while (res_seen - base < 6 && k < 600) begin @(posedge clk); k++; end
    #1;
    check_eq("depth_results", res_seen - base, 6);

    // Reset while a command is running
    do_reset();
    eng_run_len = 8;
    push_cmd(24'h440000, 12'h300, 2'd0);
    wait_issue("run_issue");
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    eng_run_len = 0;
    push_cmd(24'h440000, 12'h100, 2'd0);
    wait_res("after_rst", 8'd5, 0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid   = ($urandom_range(0, 9) < 4);
      bus.cmd_central = 24'($urandom);
      bus.cmd_radius  = 12'($urandom);
      bus.cmd_mode    = 2'($urandom);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!idle && k < 400);
    check_eq("drain_idle", idle, 1);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/set_cmd_feeder.md
Name: set_cmd_feeder

Overview:
- Command scheduler that sits directly upstream of the SET circle-coverage engine.
- Buffers (central, radius, mode) commands from the host in a FIFO and issues each one during the engine's single busy-low read cycle.
- Waits for the engine's valid pulse, then returns the candidate count tagged with the command's sequence number.
- Ignores any "dummy" engine runs that occur while nothing was issued.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
TAG_W, 4, width of command sequence tag

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command present
cmd_ready  out  1  FIFO can accept; = !full
cmd_central  in  24  {ax,ay,bx,by,cx,cy}, 4 bits each
cmd_radius  in  12  {ra,rb,rc}
cmd_mode  in  2  set operation 0..3
set_en  out  1  load strobe to engine
set_central  out  24  FIFO head central
set_radius  out  12  FIFO head radius
set_mode  out  2  FIFO head mode
set_busy  in  1  engine busy; low only during its read cycle
set_valid  in  1  engine result pulse
set_candidate  in  8  engine result count
res_valid  out  1  one-cycle result pulse
res_candidate  out  8  captured count
res_tag  out  TAG_W  sequence tag of the completed command
idle  out  1  FIFO empty and state IDLE

Behaviour:
- Reset: the interface is fixed as one clock with an asynchronous, active-low reset. While rst_n is low:
  - FSM = IDLE; FIFO pointers and count = 0; tag counter = 0.
  - res_valid = 0, res_candidate = 0, res_tag = 0.
  - cmd_ready = 1, set_en = 0, idle = 1.
- Push: on cmd_valid && cmd_ready, store {central, radius, mode, tag}, then tag += 1 (wraps mod 2^TAG_W).
  - cmd_ready depends only on the registered count, so there is no push while full, even if a pop occurs in the same cycle.
- Head outputs: set_central, set_radius and set_mode are driven combinationally from the FIFO head entry. Their value is don't-care when the FIFO is empty.
- FSM states: IDLE, ISSUE, RUN, RESP.
- IDLE: go to ISSUE when count != 0.
- ISSUE: set_en = !set_busy, combinational.
  - When set_en = 1: pop the head, latch its tag into cur_tag, go to RUN.
  - A set_valid seen in ISSUE belongs to a dummy engine run. It is discarded: no res_valid, no state change.
- RUN: set_en = 0. On set_valid: capture set_candidate and cur_tag, go to RESP.
- RESP: res_valid = 1 for exactly this one cycle, with res_candidate/res_tag holding the captured values. Next state is ISSUE if count != 0, else IDLE.
- set_en is 0 in every state except ISSUE.
- res_candidate and res_tag hold their values after the RESP cycle.
- Latency:
  - res_valid is asserted 1 cycle after set_valid.
  - Back-to-back operation: the engine's read cycle falls 2 cycles after its valid pulse, so it coincides with the cycle after RESP. When the FIFO is non-empty, that next command issues with no lost engine run.
- First command after reset: issue waits for set_busy = 0. If the engine passes its read cycle while the feeder is in IDLE, the next read cycle is used and the resulting extra set_valid is discarded.
- Push into an empty FIFO: no bypass. set_en can assert no earlier than the cycle after the push.
- Reset mid-operation: all state is cleared immediately and the in-flight result is lost. A set_valid arriving after reset, while the feeder is in IDLE or ISSUE, is discarded.
- idle = (count == 0) && (state == IDLE).

Optional Feature:
- Macro SET_FEED_STAT_EN.
- When defined, adds three outputs, each an 8-bit saturating counter cleared by rst_n:
  - stat_issued: incremented on set_en.
  - stat_done: incremented on res_valid.
  - stat_dummy: incremented on each discarded set_valid.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Single command, central A=(4,4), radius ra=2, mode 0 -> one set_en pulse during the engine's read cycle; res_valid with res_candidate=13, res_tag=0.
- Mode 1 with A=B=(4,4), ra=rb=2 -> res_candidate=13, res_tag=0.
- Mode 2 with the same A=B -> res_candidate=0.
- Three commands pushed back-to-back with mode 0, ra=1,2,3 at (4,4) -> results 5, 13, 29 with tags 0, 1, 2. Each set_en occurs exactly 2 cycles after the preceding set_valid, with no dummy runs between commands.
- DEPTH=4: push 6 commands while the engine is busy -> cmd_ready drops after 5 accepted (1 issued + 4 stored). cmd_ready returns high the cycle after the next pop, and all 6 results arrive in order.
- Empty FIFO after reset: the engine completes a dummy run -> set_valid produces no res_valid and stat_dummy=1 (with SET_FEED_STAT_EN). A command pushed afterwards completes normally with tag 0.
- Assert rst_n low while in RUN -> outputs return to reset values at once. The later engine valid is ignored, and a fresh command after release completes with tag 0.
